// File: rtl/config_frame_loader.sv
// -----------------------------------------------------------------------------
// config_frame_loader
//
// Converts a 32-bit configuration word stream (sync word, command header,
// frame data) into frame writes for the fabric configuration latch array.
// Each frame is presented on frame_data for a SETUP cycle, strobed into the
// selected latch row for one STROBE cycle, and held for one HOLD cycle, so
// the data is stable across the whole transparent window of the latch.
//
// Command header: [31:24] column, [23:16] frame count N, [15:0] ignored.
//
// Optional build macro: CONFIG_CHECKSUM_EN
//   When defined, a trailing checksum word follows the last frame. It must
//   equal the XOR of the command word and all N data words. A mismatch sets
//   cfg_error. Frames already written stay written.
//
// Ports:
//   CLK           configuration clock
//   resetn        asynchronous active-low reset
//   in_data       stream word
//   in_valid      in_data valid
//   in_ready      loader accepts in_data this cycle
//   frame_data    data presented to the latch rows
//   frame_strobe  one-hot latch enable for the selected column
//   col_sel       column targeted by frame_strobe
//   busy          high from sync detection until the frame sequence completes
//   cfg_error     sticky error flag, cleared only by reset
//   done          one-cycle pulse when a command completes
// -----------------------------------------------------------------------------
module config_frame_loader #(
    parameter int unsigned FRAME_BITS = 32,
    parameter int unsigned MAX_FRAMES = 20,
    parameter int unsigned NUM_COLS   = 16,
    parameter logic [31:0] SYNC_WORD  = 32'hFAB0_FAB1
) (
    input  logic                        CLK,
    input  logic                        resetn,
    input  logic [31:0]                 in_data,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic [FRAME_BITS-1:0]       frame_data,
    output logic [MAX_FRAMES-1:0]       frame_strobe,
    output logic [$clog2(NUM_COLS)-1:0] col_sel,
    output logic                        busy,
    output logic                        cfg_error,
    output logic                        done
);

    localparam int unsigned COL_W = $clog2(NUM_COLS);
    // Frame index and count must be able to represent MAX_FRAMES itself.
    localparam int unsigned K_W   = $clog2(MAX_FRAMES + 1);

    typedef enum logic [2:0] {
        ST_HUNT   = 3'd0,
        ST_CMD    = 3'd1,
        ST_DATA   = 3'd2,
        ST_SETUP  = 3'd3,
        ST_STROBE = 3'd4,
        ST_HOLD   = 3'd5
`ifdef CONFIG_CHECKSUM_EN
        , ST_CHK  = 3'd6
`endif
    } state_t;

    state_t                  state_r;
    logic                    in_ready_r;
    logic [FRAME_BITS-1:0]   frame_data_r;
    logic [MAX_FRAMES-1:0]   frame_strobe_r;
    logic [COL_W-1:0]        col_sel_r;
    logic                    busy_r;
    logic                    cfg_error_r;
    logic                    done_r;
    logic [K_W-1:0]          k_r;
    logic [K_W-1:0]          n_r;
`ifdef CONFIG_CHECKSUM_EN
    logic [31:0]             csum_r;
`endif

    logic                    xfer_s;
    logic [7:0]              cmd_col_s;
    logic [7:0]              cmd_n_s;
    logic                    cmd_bad_s;
    logic [K_W-1:0]          k_next_s;
    logic                    last_s;

    // One-hot latch enable for frame index idx.
    function automatic logic [MAX_FRAMES-1:0] onehot(input logic [K_W-1:0] idx);
        onehot = {{(MAX_FRAMES-1){1'b0}}, 1'b1} << idx;
    endfunction

    // Running XOR checksum step over the command and data words.
    function automatic logic [31:0] csum_step(input logic [31:0] acc,
                                              input logic [31:0] word);
        csum_step = acc ^ word;
    endfunction

    assign xfer_s    = in_valid & in_ready_r;
    assign cmd_col_s = in_data[31:24];
    assign cmd_n_s   = in_data[23:16];
    // Header checks are done on the full 8-bit fields before truncation.
    assign cmd_bad_s = (cmd_n_s == 8'd0) ||
                       ({24'd0, cmd_n_s} > MAX_FRAMES) ||
                       ({24'd0, cmd_col_s} >= NUM_COLS);
    assign k_next_s  = k_r + K_W'(1'b1);
    assign last_s    = (k_next_s == n_r);

    // Loader sequencer: stream parsing and frame setup/strobe/hold timing.
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            state_r        <= ST_HUNT;
            in_ready_r     <= 1'b0;
            frame_data_r   <= '0;
            frame_strobe_r <= '0;
            col_sel_r      <= '0;
            busy_r         <= 1'b0;
            cfg_error_r    <= 1'b0;
            done_r         <= 1'b0;
            k_r            <= '0;
            n_r            <= '0;
`ifdef CONFIG_CHECKSUM_EN
            csum_r         <= 32'd0;
`endif
        end else begin
            // Strobe and done are single-cycle; only the states below raise them.
            done_r         <= 1'b0;
            frame_strobe_r <= '0;
            case (state_r)
                ST_HUNT: begin
                    in_ready_r <= 1'b1;
                    if (xfer_s && (in_data == SYNC_WORD)) begin
                        busy_r  <= 1'b1;
                        state_r <= ST_CMD;
                    end else begin
                        state_r <= ST_HUNT;
                    end
                end
                ST_CMD: begin
                    if (xfer_s) begin
                        if (cmd_bad_s) begin
                            cfg_error_r <= 1'b1;
                            busy_r      <= 1'b0;
                            state_r     <= ST_HUNT;
                        end else begin
                            col_sel_r <= cmd_col_s[COL_W-1:0];
                            n_r       <= cmd_n_s[K_W-1:0];
                            k_r       <= '0;
`ifdef CONFIG_CHECKSUM_EN
                            csum_r    <= in_data;
`endif
                            state_r   <= ST_DATA;
                        end
                    end else begin
                        state_r <= ST_CMD;
                    end
                end
                ST_DATA: begin
                    // Any value here is frame data, including the sync pattern.
                    if (xfer_s) begin
                        frame_data_r <= FRAME_BITS'(in_data);
                        in_ready_r   <= 1'b0;
`ifdef CONFIG_CHECKSUM_EN
                        csum_r       <= csum_step(csum_r, in_data);
`endif
                        state_r      <= ST_SETUP;
                    end else begin
                        state_r <= ST_DATA;
                    end
                end
                ST_SETUP: begin
                    frame_strobe_r <= onehot(k_r);
                    state_r        <= ST_STROBE;
                end
                ST_STROBE: begin
                    state_r <= ST_HOLD;
                end
                ST_HOLD: begin
                    k_r        <= k_next_s;
                    in_ready_r <= 1'b1;
                    if (last_s) begin
`ifdef CONFIG_CHECKSUM_EN
                        state_r <= ST_CHK;
`else
                        done_r  <= 1'b1;
                        busy_r  <= 1'b0;
                        state_r <= ST_HUNT;
`endif
                    end else begin
                        state_r <= ST_DATA;
                    end
                end
`ifdef CONFIG_CHECKSUM_EN
                ST_CHK: begin
                    if (xfer_s) begin
                        if (in_data != csum_r) begin
                            cfg_error_r <= 1'b1;
                        end else begin
                            cfg_error_r <= cfg_error_r;
                        end
                        done_r  <= 1'b1;
                        busy_r  <= 1'b0;
                        state_r <= ST_HUNT;
                    end else begin
                        state_r <= ST_CHK;
                    end
                end
`endif
                default: begin
                    // Unreachable encoding: drop back to hunting for sync.
                    in_ready_r <= 1'b1;
                    busy_r     <= 1'b0;
                    state_r    <= ST_HUNT;
                end
            endcase
        end
    end

    assign in_ready     = in_ready_r;
    assign frame_data   = frame_data_r;
    assign frame_strobe = frame_strobe_r;
    assign col_sel      = col_sel_r;
    assign busy         = busy_r;
    assign cfg_error    = cfg_error_r;
    assign done         = done_r;

endmodule

// File: tb/tb_config_frame_loader.sv
// -----------------------------------------------------------------------------
// tb_config_frame_loader
//
// Directed bench for config_frame_loader with hand-computed expectations.
// Build with CONFIG_CHECKSUM_EN defined to also exercise the checksum tail.
// -----------------------------------------------------------------------------
module tb_config_frame_loader;

    localparam logic [31:0] SYNC = 32'hFAB0_FAB1;

    logic        CLK;
    logic        resetn;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] frame_data;
    logic [19:0] frame_strobe;
    logic [3:0]  col_sel;
    logic        busy;
    logic        cfg_error;
    logic        done;

    int checks;
    int errors;

    config_frame_loader dut (
        .CLK          (CLK),
        .resetn       (resetn),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .frame_data   (frame_data),
        .frame_strobe (frame_strobe),
        .col_sel      (col_sel),
        .busy         (busy),
        .cfg_error    (cfg_error),
        .done         (done)
    );

    // 10 ns configuration clock.
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Guard against a stalled run.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Present one word and wait (bounded) until it is accepted; returns #1 after the accepting edge.
    task automatic send_word(input logic [31:0] w);
        int cnt;
        cnt = 0;
        @(negedge CLK);
        in_data  = w;
        in_valid = 1'b1;
        while (!in_ready && cnt < 20) begin
            @(negedge CLK);
            cnt++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL send_word_accept: in_ready=%b required=1 for word %h", in_ready, w);
        end
        @(posedge CLK);
        #1;
        in_valid = 1'b0;
    endtask

    // Pulse reset and return #1 after the first edge following release.
    task automatic do_reset;
        @(negedge CLK);
        resetn   = 1'b0;
        in_valid = 1'b0;
        repeat (2) @(negedge CLK);
        resetn = 1'b1;
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset;
        #12;
        checks++;
        if ({in_ready, busy, cfg_error, done} !== 4'b0000 || frame_strobe !== 20'h0 ||
            frame_data !== 32'h0 || col_sel !== 4'h0) begin
            errors++;
            $display("FAIL reset_outputs: rdy=%b busy=%b err=%b done=%b strb=%h data=%h col=%h required all 0",
                     in_ready, busy, cfg_error, done, frame_strobe, frame_data, col_sel);
        end
        @(negedge CLK);
        resetn = 1'b1;
        @(posedge CLK);
        #1;
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_hunt: in_ready=%b busy=%b required 1 0", in_ready, busy);
        end
    endtask

    task automatic test_basic_load;
        logic [31:0] w [0:1];
        logic [19:0] exp_s;
        w[0] = 32'hAAAA_AAAA;
        w[1] = 32'h5555_5555;
        send_word(32'h0000_1234);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL junk_ignored: busy=%b required 0", busy);
        end
        send_word(SYNC);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL sync_busy: busy=%b required 1", busy);
        end
        send_word(32'h0302_0000);
        checks++;
        if (col_sel !== 4'd3 || frame_strobe !== 20'h0) begin
            errors++;
            $display("FAIL cmd_col: col_sel=%0d strobe=%h required 3 0", col_sel, frame_strobe);
        end
        for (int k = 0; k < 2; k++) begin
            send_word(w[k]);
            checks++;
            if (frame_strobe !== 20'h0 || frame_data !== w[k] || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL setup_%0d: strobe=%h data=%h rdy=%b required 0 %h 0",
                         k, frame_strobe, frame_data, in_ready, w[k]);
            end
            @(posedge CLK);
            #1;
            exp_s = 20'h1 << k;
            checks++;
            if (frame_strobe !== exp_s || frame_data !== w[k] || col_sel !== 4'd3 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL strobe_%0d: strobe=%h data=%h col=%0d rdy=%b required %h %h 3 0",
                         k, frame_strobe, frame_data, col_sel, in_ready, exp_s, w[k]);
            end
            @(posedge CLK);
            #1;
            checks++;
            if (frame_strobe !== 20'h0 || frame_data !== w[k] || done !== 1'b0) begin
                errors++;
                $display("FAIL hold_%0d: strobe=%h data=%h done=%b required 0 %h 0",
                         k, frame_strobe, frame_data, done, w[k]);
            end
        end
`ifdef CONFIG_CHECKSUM_EN
        send_word(32'hFCFD_FFFF);
`else
        @(posedge CLK);
        #1;
`endif
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || cfg_error !== 1'b0) begin
            errors++;
            $display("FAIL basic_done: done=%b busy=%b err=%b required 1 0 0", done, busy, cfg_error);
        end
        @(posedge CLK);
        #1;
        checks++;
        if (done !== 1'b0 || frame_data !== w[1] || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL basic_after: done=%b data=%h rdy=%b required 0 %h 1",
                     done, frame_data, in_ready, w[1]);
        end
    endtask

    task automatic test_bad_count;
        logic [19:0] seen;
        send_word(SYNC);
        send_word(32'h0015_0000);
        checks++;
        if (cfg_error !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL badn_err: err=%b busy=%b required 1 0", cfg_error, busy);
        end
        seen = frame_strobe;
        repeat (4) begin
            @(posedge CLK);
            #1;
            seen = seen | frame_strobe;
        end
        checks++;
        if (seen !== 20'h0) begin
            errors++;
            $display("FAIL badn_nostrobe: strobe_seen=%h required 0", seen);
        end
        send_word(SYNC);
        send_word(32'h0501_0000);
        send_word(32'h0F0F_0F0F);
        @(posedge CLK);
        #1;
        checks++;
        if (frame_strobe !== 20'h1 || col_sel !== 4'd5 || frame_data !== 32'h0F0F_0F0F) begin
            errors++;
            $display("FAIL badn_recover: strobe=%h col=%0d data=%h required 1 5 0f0f0f0f",
                     frame_strobe, col_sel, frame_data);
        end
        @(posedge CLK);
        #1;
`ifdef CONFIG_CHECKSUM_EN
        send_word(32'h0A0E_0F0F);
`else
        @(posedge CLK);
        #1;
`endif
        checks++;
        if (done !== 1'b1 || cfg_error !== 1'b1) begin
            errors++;
            $display("FAIL badn_sticky: done=%b err=%b required 1 1", done, cfg_error);
        end
    endtask

    task automatic test_bad_col;
        logic [19:0] seen;
        do_reset();
        send_word(SYNC);
        send_word(32'h1001_0000);
        checks++;
        if (cfg_error !== 1'b1 || busy !== 1'b0 || col_sel !== 4'd0) begin
            errors++;
            $display("FAIL badcol_err: err=%b busy=%b col=%0d required 1 0 0", cfg_error, busy, col_sel);
        end
        seen = frame_strobe;
        repeat (4) begin
            @(posedge CLK);
            #1;
            seen = seen | frame_strobe;
        end
        checks++;
        if (seen !== 20'h0) begin
            errors++;
            $display("FAIL badcol_nostrobe: strobe_seen=%h required 0", seen);
        end
    endtask

    task automatic test_sync_as_data;
        do_reset();
        send_word(SYNC);
        send_word(32'h0001_0000);
        send_word(SYNC);
        checks++;
        if (frame_data !== SYNC || busy !== 1'b1) begin
            errors++;
            $display("FAIL syncdata_data: data=%h busy=%b required fab0fab1 1", frame_data, busy);
        end
        @(posedge CLK);
        #1;
        checks++;
        if (frame_strobe !== 20'h1 || col_sel !== 4'd0) begin
            errors++;
            $display("FAIL syncdata_strobe: strobe=%h col=%0d required 1 0", frame_strobe, col_sel);
        end
        @(posedge CLK);
        #1;
`ifdef CONFIG_CHECKSUM_EN
        send_word(32'hFAB1_FAB1);
`else
        @(posedge CLK);
        #1;
`endif
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || cfg_error !== 1'b0) begin
            errors++;
            $display("FAIL syncdata_done: done=%b busy=%b err=%b required 1 0 0", done, busy, cfg_error);
        end
    endtask

    task automatic test_reset_mid_strobe;
        do_reset();
        send_word(SYNC);
        send_word(32'h0002_0000);
        send_word(32'h1234_5678);
        @(posedge CLK);
        #1;
        checks++;
        if (frame_strobe !== 20'h1) begin
            errors++;
            $display("FAIL midrst_pre: strobe=%h required 1", frame_strobe);
        end
        resetn = 1'b0;
        #1;
        checks++;
        if (frame_strobe !== 20'h0 || {in_ready, busy, cfg_error, done} !== 4'b0000 ||
            frame_data !== 32'h0 || col_sel !== 4'h0) begin
            errors++;
            $display("FAIL midrst_async: strb=%h rdy=%b busy=%b err=%b done=%b data=%h col=%h required all 0",
                     frame_strobe, in_ready, busy, cfg_error, done, frame_data, col_sel);
        end
        @(negedge CLK);
        resetn = 1'b1;
        @(posedge CLK);
        #1;
        send_word(SYNC);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL midrst_resync: busy=%b required 1", busy);
        end
        send_word(32'h0701_0000);
        checks++;
        if (col_sel !== 4'd7) begin
            errors++;
            $display("FAIL midrst_cmd: col_sel=%0d required 7", col_sel);
        end
    endtask

`ifdef CONFIG_CHECKSUM_EN
    task automatic test_checksum;
        do_reset();
        send_word(SYNC);
        send_word(32'h0001_0000);
        send_word(32'h0000_00FF);
        send_word(32'h0001_00FF);
        checks++;
        if (done !== 1'b1 || cfg_error !== 1'b0) begin
            errors++;
            $display("FAIL csum_good: done=%b err=%b required 1 0", done, cfg_error);
        end
        send_word(SYNC);
        send_word(32'h0001_0000);
        send_word(32'h0000_00FF);
        send_word(32'h0000_0000);
        checks++;
        if (done !== 1'b1 || cfg_error !== 1'b1) begin
            errors++;
            $display("FAIL csum_bad: done=%b err=%b required 1 1", done, cfg_error);
        end
    endtask
`endif

    initial begin
        checks   = 0;
        errors   = 0;
        resetn   = 1'b0;
        in_valid = 1'b0;
        in_data  = 32'h0;
        test_reset();
        test_basic_load();
        test_bad_count();
        test_bad_col();
        test_sync_as_data();
        test_reset_mid_strobe();
`ifdef CONFIG_CHECKSUM_EN
        test_checksum();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
